// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and defaults for the two-master Avalon-MM bus arbiter.
// Pulled in by the arbiter top and its watchdog.
package avalon_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam int unsigned TIMEOUT_DEFAULT  = 255;
    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;
    localparam int unsigned WDOG_W           = 16;

endpackage

// File: rtl/avalon_bus_arbiter_bus_watchdog.sv
// Stall watchdog: counts slave waitrequest cycles of the current grant and
// flags the cycle on which the TIMEOUT-th stall occurs.
module bus_watchdog
    import avalon_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count;

    // count holds the number of stalls already seen, so the current stall is count+1
    assign expired = enable && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired && (count != '1)) begin
            count <= count + WDOG_W'(1);
        end
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave between the MCU (m0) and the
// debug master (m1), with a stall watchdog that aborts hung transfers.
module avalon_bus_arbiter
    import avalon_bus_arbiter_pkg::*;
#(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 16,
    parameter int unsigned   TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_writedata,
    input  logic          m0_read,
    input  logic          m0_write,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_waitrequest,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_writedata,
    input  logic          m1_read,
    input  logic          m1_write,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_waitrequest,
    output logic [AW-1:0] s_address,
    output logic [DW-1:0] s_writedata,
    output logic          s_read,
    output logic          s_write,
    input  logic [DW-1:0] s_readdata,
    input  logic          s_waitrequest,
    output logic          mcu_hold,
    output logic          timeout_err,
    output logic [1:0]    arb_state
);

    // Handshake: a master holds read/write (and address/data) stable until it
    // sees waitrequest low at a rising edge; that edge completes the transfer.

    arb_state_t state;
    arb_state_t state_next;
    logic       last_grant;
    logic       last_grant_next;
    logic       req0;
    logic       req1;
    logic       gnt0;
    logic       gnt1;
    logic       gnt_req;
    logic       done;
    logic       abort;

    assign req0    = m0_read || m0_write;
    assign req1    = m1_read || m1_write;
    assign gnt0    = (state == ST_GRANT0);
    assign gnt1    = (state == ST_GRANT1);
    assign gnt_req = (gnt0 && req0) || (gnt1 && req1);
    assign done    = gnt_req && !s_waitrequest;

    assign mcu_hold  = gnt1;
    assign arb_state = state;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .enable (gnt_req && s_waitrequest),
        .expired(abort)
    );

    // A simultaneous read and write is forwarded as a write only.
    always_comb begin
        s_address   = '0;
        s_writedata = '0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        if (gnt0) begin
            s_address   = m0_address;
            s_writedata = m0_writedata;
            s_write     = m0_write && !abort;
            s_read      = m0_read && !m0_write && !abort;
        end else if (gnt1) begin
            s_address   = m1_address;
            s_writedata = m1_writedata;
            s_write     = m1_write && !abort;
            s_read      = m1_read && !m1_write && !abort;
        end
    end

    always_comb begin
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        if (gnt0) begin
            m0_waitrequest = s_waitrequest && !abort;
        end
        if (gnt1) begin
            m1_waitrequest = s_waitrequest && !abort;
        end
        m0_readdata = (gnt0 && abort) ? ERR_DATA : s_readdata;
        m1_readdata = (gnt1 && abort) ? ERR_DATA : s_readdata;
    end

    // Every grant returns through IDLE, so ownership never switches mid-transfer.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_next = last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (req0) begin
                    state_next = ST_GRANT0;
                end else if (req1) begin
                    state_next = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (abort || done) begin
                    state_next      = ST_IDLE;
                    last_grant_next = 1'b0;
                end else if (!req0) begin
                    state_next = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (abort || done) begin
                    state_next      = ST_IDLE;
                    last_grant_next = 1'b1;
                end else if (!req1) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: master driver tasks, a simple slave
// model and a scoreboard that checks each completed transfer in order.
module tb_avalon_bus_arbiter;

    localparam int W = 35;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_read, m0_write, m0_waitrequest;
    logic [15:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_read, m1_write, m1_waitrequest;
    logic [15:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic        mcu_hold, timeout_err;
    logic [1:0]  arb_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int swr_cnt  = 0;
    int hold_cnt = 0;
    int viol_cnt = 0;

    logic [15:0] slave_rdata;
    int          slave_stalls;
    logic        slave_stuck;
    logic        rdata_from_addr;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(
        .TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_address    (m0_address),
        .m0_writedata  (m0_writedata),
        .m0_read       (m0_read),
        .m0_write      (m0_write),
        .m0_readdata   (m0_readdata),
        .m0_waitrequest(m0_waitrequest),
        .m1_address    (m1_address),
        .m1_writedata  (m1_writedata),
        .m1_read       (m1_read),
        .m1_write      (m1_write),
        .m1_readdata   (m1_readdata),
        .m1_waitrequest(m1_waitrequest),
        .s_address     (s_address),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .mcu_hold      (mcu_hold),
        .timeout_err   (timeout_err),
        .arb_state     (arb_state)
    );

    // Slave: stalls slave_stalls cycles per transfer, or forever when stuck.
    assign s_waitrequest = slave_stuck || (busy_cnt < slave_stalls);
    assign s_readdata    = rdata_from_addr ? (s_address ^ 16'hA5A5) : slave_rdata;

    always @(posedge clk) begin
        if ((s_read || s_write) && s_waitrequest) busy_cnt <= busy_cnt + 1;
        else busy_cnt <= 0;
    end

    function automatic logic [W-1:0] mk(input logic ab, input logic m, input logic rd,
                                        input logic [15:0] a, input logic [15:0] d);
        return {ab, m, rd, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic score(input logic m, input logic rd, input logic [15:0] rdata);
        logic [W-1:0] act;
        logic [W-1:0] exp;
        act = {!(s_read || s_write), m, rd, s_address, rd ? rdata : s_writedata};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_completion m%0d: got %0h, expected nothing", m, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL scoreboard m%0d: got %0h, expected %0h", m, act, exp);
            end
        end
        check("mcu_hold_owner", {31'd0, mcu_hold}, {31'd0, m});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if ((m0_read || m0_write) && !m0_waitrequest)
                score(1'b0, m0_read && !m0_write, m0_readdata);
            if ((m1_read || m1_write) && !m1_waitrequest)
                score(1'b1, m1_read && !m1_write, m1_readdata);
            if (s_write) swr_cnt++;
            if (mcu_hold) hold_cnt++;
            if (mcu_hold && (m0_read || m0_write) && !m0_waitrequest) viol_cnt++;
        end
    end

    task automatic m_xfer(input int m, input logic wr, input logic [15:0] addr,
                          input logic [15:0] data, output int waits);
        logic done;
        if (m == 0) begin
            m0_address = addr; m0_writedata = data; m0_write = wr; m0_read = !wr;
        end else begin
            m1_address = addr; m1_writedata = data; m1_write = wr; m1_read = !wr;
        end
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if ((m == 0) ? m0_waitrequest : m1_waitrequest) waits++;
            else done = 1'b1;
        end
        check("xfer_complete", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_read = 1'b0; m0_write = 1'b0;
        end else begin
            m1_read = 1'b0; m1_write = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w0, w1, s0, h0, v0;
        reset = 1'b1;
        m0_address = '0; m0_writedata = '0; m0_read = 1'b0; m0_write = 1'b0;
        m1_address = '0; m1_writedata = '0; m1_read = 1'b0; m1_write = 1'b0;
        slave_rdata = '0; slave_stalls = 0; slave_stuck = 1'b0; rdata_from_addr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_state", {30'd0, arb_state}, 32'd0);
        check("rst_mcu_hold", {31'd0, mcu_hold}, 32'd0);
        check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check("rst_s_cmd", {30'd0, s_read, s_write}, 32'd0);
        check("rst_s_address", {16'd0, s_address}, 32'd0);
        check("rst_waitreq", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd0);
        @(posedge clk); #1;

        // Single m0 read with zero-wait slave.
        slave_rdata = 16'h1234;
        h0 = hold_cnt;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0010, 16'h1234));
        m_xfer(0, 1'b0, 16'h0010, 16'h0000, w0);
        check("m0_read_stalls", w0, 32'd1);
        check("m0_read_no_hold", hold_cnt - h0, 32'd0);
        @(posedge clk); #1;

        // Two ties after m0 was last: m1 wins both times.
        rdata_from_addr = 1'b1;
        repeat (2) begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0101, 16'hA4A4));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0100, 16'hA4A5));
            fork
                m_xfer(0, 1'b0, 16'h0100, 16'h0000, w0);
                m_xfer(1, 1'b0, 16'h0101, 16'h0000, w1);
            join
            check("tie_m1_stalls", w1, 32'd1);
            check("tie_m0_stalls", w0, 32'd3);
            @(posedge clk); #1;
        end

        // m1 alone, then a tie goes to m0.
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0102, 16'h5555));
        m_xfer(1, 1'b1, 16'h0102, 16'h5555, w1);
        @(posedge clk); #1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0103, 16'h6666));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0104, 16'hA4A1));
        fork
            m_xfer(0, 1'b1, 16'h0103, 16'h6666, w0);
            m_xfer(1, 1'b0, 16'h0104, 16'h0000, w1);
        join
        check("rr_m0_stalls", w0, 32'd1);
        check("rr_m1_stalls", w1, 32'd3);
        @(posedge clk); #1;

        // m1 write with a 3-cycle slave stall while m0 waits behind it.
        slave_stalls = 3;
        s0 = swr_cnt;
        v0 = viol_cnt;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0200, 16'hBEEF));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0300, 16'hA6A5));
        fork
            m_xfer(1, 1'b1, 16'h0200, 16'hBEEF, w1);
            begin
                @(posedge clk); #1;
                m_xfer(0, 1'b0, 16'h0300, 16'h0000, w0);
            end
        join
        check("stall_m1_waits", w1, 32'd4);
        check("stall_s_write_cycles", swr_cnt - s0, 32'd4);
        check("stall_m0_held", viol_cnt - v0, 32'd0);
        check("stall_m0_waits", w0, 32'd8);
        slave_stalls = 0;
        @(posedge clk); #1;

        // Hung slave: abort on the 4th stall cycle.
        @(negedge clk);
        check("pre_abort_err", {31'd0, timeout_err}, 32'd0);
        @(posedge clk); #1;
        slave_stuck = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 16'h0040, 16'hDEAD));
        m_xfer(0, 1'b0, 16'h0040, 16'h0000, w0);
        check("abort_waits", w0, 32'd4);
        @(negedge clk);
        check("abort_err_set", {31'd0, timeout_err}, 32'd1);
        check("abort_idle", {30'd0, arb_state}, 32'd0);
        @(posedge clk); #1;
        slave_stuck = 1'b0;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0050, 16'h7777));
        m_xfer(1, 1'b1, 16'h0050, 16'h7777, w1);
        @(negedge clk);
        check("err_sticky", {31'd0, timeout_err}, 32'd1);
        @(posedge clk); #1;

        // Reset while m1 is stalled in its grant.
        slave_stuck = 1'b1;
        m1_address = 16'h0060;
        m1_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_hold_before", {31'd0, mcu_hold}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_state", {30'd0, arb_state}, 32'd0);
        check("rst_mid_hold", {31'd0, mcu_hold}, 32'd0);
        check("rst_mid_err", {31'd0, timeout_err}, 32'd0);
        check("rst_mid_s_cmd", {30'd0, s_read, s_write}, 32'd0);
        #1;
        m1_read = 1'b0;
        slave_stuck = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 Parameter AW, default 16, address width of all ports.
REQ-002 Parameter DW, default 16, data width of all ports.
REQ-003 Parameter TIMEOUT, default 255, maximum slave waitrequest cycles before abort; legal range 1..65535.
REQ-004 Parameter ERR_DATA, default 16'hDEAD, readdata returned on an aborted read.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 m0_address, m1_address  input  AW  master 0 (MCU av), master 1 (visor dbg_av) address.
REQ-008 m0_writedata, m1_writedata  input  DW  write data per master.
REQ-009 m0_read, m0_write, m1_read, m1_write  input  1  Avalon-MM commands per master.
REQ-010 m0_readdata, m1_readdata  output  DW  read data per master.
REQ-011 m0_waitrequest, m1_waitrequest  output  1  stall per master.
REQ-012 s_address  output  AW; s_writedata  output  DW; s_read, s_write  output  1  shared slave command.
REQ-013 s_readdata  input  DW; s_waitrequest  input  1  shared slave response.
REQ-014 mcu_hold  output  1  high while master 1 owns the bus; feeds the mcu_wait path.
REQ-015 timeout_err  output  1  sticky flag, set on any abort.

Function
REQ-016 States: IDLE, GRANT0, GRANT1; state register only, grant decoded from state.
REQ-017 A master requests when its read or write is high; read and write both high is treated as write.
REQ-018 IDLE with one requester: grant that master on next edge.
REQ-019 IDLE with both requesting: grant the master not granted last (round-robin pointer last_grant); after reset last_grant=0, so master 1 wins the first tie.
REQ-020 In GRANTn, slave command outputs = master n inputs combinationally; in IDLE s_read=s_write=0, s_address/s_writedata=0.
REQ-021 In GRANTn, mn_waitrequest = s_waitrequest; the other master's waitrequest = 1 while it requests.
REQ-022 In IDLE, every requesting master sees waitrequest=1 (minimum one stall cycle per transfer).
REQ-023 m0_readdata and m1_readdata both = s_readdata, except ERR_DATA on the abort cycle to the aborted master.
REQ-024 Completion: in GRANTn with mn request and s_waitrequest=0 -> transfer done, last_grant<=n, next state IDLE.
REQ-025 Master n drops request in GRANTn before completion -> IDLE next edge, last_grant unchanged.
REQ-026 Watchdog: 16-bit counter cleared on entering GRANTn, increments each GRANTn cycle with s_waitrequest=1.
REQ-027 Counter reaching TIMEOUT: that cycle mn_waitrequest forced 0, readdata=ERR_DATA, s_read/s_write forced 0, timeout_err<=1, next state IDLE, last_grant<=n.
REQ-028 Counter never wraps; abort takes precedence over normal completion in the same cycle.
REQ-029 timeout_err cleared only by reset.
REQ-030 mcu_hold = (state==GRANT1), combinational from state.
REQ-031 Grant never changes while a granted transfer is outstanding; no back-to-back grant without passing IDLE.

Reset
REQ-032 Reset: state=IDLE, last_grant=0, counter=0, timeout_err=0; outputs per REQ-020/022, mcu_hold=0.
REQ-033 Reset mid-transfer aborts silently: no ERR_DATA, no timeout_err, slave command deasserted same cycle reset is sampled-through.

Structure
REQ-034 Package holds arb_state_t enum, ERR_DATA default and TIMEOUT default constants.
REQ-035 One sub-module, bus_watchdog: counter, clear, enable, expired output.

Verification
REQ-036 m0 read addr 16'h0010, s_waitrequest low at once, s_readdata 16'h1234 -> m0 stalls 1 cycle, gets 16'h1234, mcu_hold stays 0.
REQ-037 m0 and m1 request same cycle after reset -> m1 granted first (mcu_hold=1), then m0; repeat tie -> m1 again only after m0 completes (alternation).
REQ-038 m1 write 16'hBEEF with slave stalling 3 cycles -> m0 waitrequest held 1 throughout, s_write high 4 cycles, m1 completes on cycle 4 of grant.
REQ-039 TIMEOUT=4, slave waitrequest stuck high on m0 read -> abort on 4th stall cycle, m0_readdata=16'hDEAD, timeout_err=1, bus returns to IDLE.
REQ-040 Reset asserted in GRANT1 mid-stall -> next cycle IDLE, mcu_hold=0, timeout_err=0, s_read=s_write=0.
